cla_wide_seq: RTL and testbench

Multi-cycle sequencer that adds or subtracts WIDTH-bit operands by time-multiplexing one internal 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first. The slice computes g/p per bit, four lookahead carries and a carry-out, with an explicit carry-in. The block registers the inter-nibble carry and writes the result nibble by nibble. Upstream and downstream use valid/ready handshakes. It is the wide-arithmetic front end for the team's nibble adders.

---
 rtl/cla_wide_seq_if.sv | 26 ++
 rtl/cla_wide_seq.sv | 118 +++++++++++
 tb/tb_cla_wide_seq.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/cla_wide_seq_if.sv
// Request/result bundle for cla_wide_seq: operands in, sum/flags out, each with valid/ready.
// The master side issues requests and consumes results; the slave side is the sequencer.
interface cla_wide_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow
  );
endinterface

// File: rtl/cla_wide_seq.sv
// Wide add/sub built from one 4-bit carry-lookahead slice reused per nibble, LSB first.
// Result valid NIB cycles after acceptance; held in DONE until out_ready, no new request taken meanwhile.
module cla_wide_seq #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  cla_wide_seq_if.slave io,
  output logic          busy
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;

  logic [3:0] nib_a, nib_b, g, p, s;
  logic [4:0] c;
  logic       last;

  // Carry-lookahead slice over the currently selected nibble.
  always_comb begin
    nib_a = a_q[4*idx_q +: 4];
    nib_b = b_q[4*idx_q +: 4];
    g     = nib_a & nib_b;
    p     = nib_a ^ nib_b;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s     = p ^ c[3:0];
    last  = (idx_q == IDXW'(NIB - 1));
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
          a_d     = io.a;
          b_d     = io.b ^ {WIDTH{io.sub}};
          carry_d = io.sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[4*idx_q +: 4] = s;
        carry_d                = c[4];
        idx_d                  = idx_q + IDXW'(1);
        if (last) begin
          carry_out_d = c[4];
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (s[3] != a_q[WIDTH-1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = out_valid_q;
  assign io.result    = result_q;
  assign io.carry_out = carry_out_q;
  assign io.overflow  = overflow_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_cla_wide_seq.sv
// Bench for cla_wide_seq at WIDTH=16: directed corner cases plus random ops against an integer model.
module tb_cla_wide_seq;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   vectors = 0;
  int   miscompares = 0;

  cla_wide_seq_if #(.WIDTH(W)) bus ();

  cla_wide_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .io   (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [W-1:0] r, output logic c, output logic v);
    int sa, sb, sr;
    sa = int'($signed(a));
    sb = int'($signed(b));
    sr = s ? sa - sb : sa + sb;
    v  = (sr > 32767) || (sr < -32768);
    r  = s ? a - b : a + b;
    c  = s ? (a >= b) : ((int'(a) + int'(b)) > 65535);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and return just after its acceptance edge.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    for (int k = 0; k < 30 && !bus.in_ready; k++) tick();
    check("in_ready_before_req", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    tick();
    bus.in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic finish_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input int ready_delay);
    logic [W-1:0] er;
    logic         ec, ev;
    int           lat;
    model(a, b, s, er, ec, ev);
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    check("out_valid_wait", bus.out_valid, 1);
    check("latency", lat, 4);
    check("result", bus.result, er);
    check("carry_out", bus.carry_out, ec);
    check("overflow", bus.overflow, ev);
    repeat (ready_delay) tick();
    check("result_held", bus.result, er);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("out_valid_cleared", bus.out_valid, 0);
    check("in_ready_after_out", bus.in_ready, 1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    start(a, b, s);
    finish_op(a, b, s, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb, er, er2;
    logic         rs, ec, ev, ec2, ev2;

    bus.in_valid  = 1'b1;
    bus.a         = 16'hAAAA;
    bus.b         = 16'h5555;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;

    // Reset with a request pending: it must be ignored.
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry_out", bus.carry_out, 0);
    check("rst_overflow", bus.overflow, 0);
    check("rst_busy", busy, 0);
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    check("in_ready_after_rst", bus.in_ready, 1);
    check("busy_after_rst", busy, 0);

    do_op(16'h1234, 16'h0FFF, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0);
    do_op(16'h0005, 16'h0007, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1);
    do_op(16'h0000, 16'h0000, 1'b1);

    // Backpressure: hold the result while a second request waits.
    start(16'hBEEF, 16'h1111, 1'b1);
    bus.a = 16'h0F0F;
    bus.b = 16'hF0F0;
    bus.sub = 1'b0;
    model(16'hBEEF, 16'h1111, 1'b1, er, ec, ev);
    for (int k = 0; k < 30 && !bus.out_valid; k++) tick();
    check("bp_out_valid", bus.out_valid, 1);
    bus.in_valid = 1'b1;
    bus.a   = 16'h4321;
    bus.b   = 16'h1234;
    bus.sub = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_hold_result", bus.result, er);
      check("bp_hold_flags", {bus.carry_out, bus.overflow}, {ec, ev});
      check("bp_in_ready_low", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_in_ready_next", bus.in_ready, 1);
    check("bp_out_valid_low", bus.out_valid, 0);
    tick();
    bus.in_valid = 1'b0;
    check("bp_second_accepted", busy, 1);
    tick();
    bus.a = $urandom;
    bus.b = $urandom;
    bus.sub = 1'b1;
    model(16'h4321, 16'h1234, 1'b0, er2, ec2, ev2);
    for (int k = 0; k < 30 && !bus.out_valid; k++) tick();
    check("bp2_out_valid", bus.out_valid, 1);
    check("bp2_result", bus.result, er2);
    check("bp2_flags", {bus.carry_out, bus.overflow}, {ec2, ev2});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Abort mid-operation at nibble index 2.
    start(16'hFFFF, 16'hFFFF, 1'b0);
    tick();
    tick();
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_no_valid", bus.out_valid, 0);
    end
    do_op(16'h0001, 16'h0001, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (n % 8 == 0) rb = ra;
      start(ra, rb, rs);
      finish_op(ra, rb, rs, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
